smg_scan_module: RTL and testbench
==================================

Name: smg_scan_module

Overview:
- Downstream stage of the two-digit seven-segment encoder. Consumes the encoded ten-digit and one-digit segment patterns (active-low, 8 bits each including DP).
- Time-multiplexes both patterns onto one shared segment bus with active-low digit selects.
- Inserts a dark interval between digits to suppress ghosting, and optionally blanks a leading zero.
- Latches both patterns once per frame so that mid-frame input changes cannot tear the display.

Parameters:
- T_DIGIT, 50000: cycles each digit is lit (1 ms at 50 MHz); must be ≥1.
- T_BLANK, 500: dark cycles after each digit; 0 means no dark interval.
- CNT_W, 16: width of the internal dwell counter; must hold max(T_DIGIT, T_BLANK) - 1.

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- RSTn  input  1  synchronous, active-low reset. One clock; reset is synchronous and active-low.
- Ten_SMG_Data  input  8  encoded ten-digit pattern, active-low segments.
- One_SMG_Data  input  8  encoded one-digit pattern, active-low segments.
- Scan_En  input  1  enables scanning. Frames start only while this is high.
- LZ_En  input  1  enables leading-zero blanking of the ten digit.
- SMG_Data  output  8  shared segment bus, active-low; 8'hFF means all segments off.
- Scan_Sig  output  2  digit selects, active-low. Bit 1 is the ten digit, bit 0 is the one digit.
- Frame_Done  output  1  one-cycle pulse on the last cycle of each frame.

Behaviour:
- All outputs are registered. State, counter and outputs update on the same edge, so outputs always match the current state.
- Reset (RSTn=0 at an edge) takes priority over everything, including mid-frame. After that edge: SMG_Data=8'hFF, Scan_Sig=2'b11, Frame_Done=0, state=IDLE, counter=0, both shadow registers=8'hFF.
- States: IDLE, TEN_ON, TEN_BLANK, ONE_ON, ONE_BLANK.
- IDLE:
  - Outputs are dark (SMG_Data=8'hFF, Scan_Sig=2'b11).
  - On an edge with Scan_En=1: load the shadow registers from Ten_SMG_Data and One_SMG_Data, go to TEN_ON, clear the counter.
  - The ten digit is therefore visible in the cycle right after the edge that sampled Scan_En high.
- TEN_ON:
  - Normally Scan_Sig=2'b01 and SMG_Data=ten shadow.
  - If LZ_En=1 and ten shadow == 8'hC0 (glyph "0"), drive Scan_Sig=2'b11 and SMG_Data=8'hFF instead. Slot timing is unchanged.
  - Lasts exactly T_DIGIT cycles, then goes to TEN_BLANK (or straight to ONE_ON when T_BLANK=0).
- TEN_BLANK: dark outputs for T_BLANK cycles, then ONE_ON.
- ONE_ON: Scan_Sig=2'b10, SMG_Data=one shadow, for T_DIGIT cycles. Then ONE_BLANK, or the end-of-frame decision when T_BLANK=0.
- ONE_BLANK: dark outputs for T_BLANK cycles.
- Frame end:
  - Frame_Done=1 during the final cycle of the frame (last ONE_BLANK cycle, or last ONE_ON cycle when T_BLANK=0); 0 at all other times.
  - Next state: if Scan_En=1 at the frame's final edge, reload the shadows and go to TEN_ON; otherwise go to IDLE.
- Frame length is 2*(T_DIGIT+T_BLANK) cycles. Back-to-back frames have no gap.
- Scan_En is sampled only in IDLE and at frame end. Deasserting it mid-frame lets the current frame complete.
- Changes on the input patterns mid-frame are ignored until the next shadow load.
- LZ_En is evaluated combinationally each cycle in TEN_ON against the shadow value.
- The counter counts 0..N-1 within each state and clears on every state change.
- Scan_Sig is never 2'b00 in any cycle: exactly one digit, or none, is selected.

Test Plan (T_DIGIT=4, T_BLANK=2, CNT_W=4 unless stated):
1. Hold RSTn=0 for 3 cycles with Scan_En=1 and inputs A4/B0 -> every cycle shows SMG_Data=FF, Scan_Sig=11, Frame_Done=0. The first frame starts only after RSTn=1.
2. Ten=8'hA4, One=8'hB0, Scan_En=1 -> repeating 12-cycle frame:
   - 4 cycles of 01/A4
   - 2 cycles of 11/FF
   - 4 cycles of 10/B0
   - 2 cycles of 11/FF, with Frame_Done=1 on the 12th cycle only.
3. Change One to 8'hF9 during the 2nd TEN_ON cycle -> that frame's ONE_ON still shows B0; the next frame shows F9. Frame_Done cadence is unchanged.
4. LZ_En=1, Ten=8'hC0, One=8'h92 -> ten slot is 11/FF, one slot is 10/92. With LZ_En=0 the ten slot is 01/C0. Frame length stays 12 in both cases.
5. Drop Scan_En during ONE_ON -> the frame completes, Frame_Done pulses, then the block sits in IDLE at 11/FF. Reassert Scan_En -> 01/<ten> appears the cycle after the sampling edge.
6. Pull RSTn=0 for one edge mid ONE_ON -> the next cycle shows FF/11/0, the block restarts from IDLE, and the shadows read FF. With T_BLANK=0: the frame is 8 cycles with no dark cycles, and Frame_Done appears on the last ONE_ON cycle.

Source files
------------

// File: rtl/smg_scan_module.sv
// Two-digit seven-segment scanner: time-multiplexes latched ten/one patterns onto a
// shared active-low segment bus, with dark gaps between digits and optional leading-zero blanking.
module smg_scan_module #(
    parameter int T_DIGIT = 50000,
    parameter int T_BLANK = 500,
    parameter int CNT_W   = 16
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [7:0] Ten_SMG_Data,
    input  logic [7:0] One_SMG_Data,
    input  logic       Scan_En,
    input  logic       LZ_En,
    output logic [7:0] SMG_Data,
    output logic [1:0] Scan_Sig,
    output logic       Frame_Done
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TEN_ON    = 3'd1,
        TEN_BLANK = 3'd2,
        ONE_ON    = 3'd3,
        ONE_BLANK = 3'd4
    } state_t;

    localparam logic             HAS_BLANK = (T_BLANK > 0);
    localparam logic [CNT_W-1:0] DIG_LAST  = CNT_W'(T_DIGIT - 1);
    localparam logic [CNT_W-1:0] BLK_LAST  = CNT_W'((T_BLANK > 0) ? (T_BLANK - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [7:0] SEG_DARK  = 8'hFF;
    localparam logic [7:0] GLYPH_0   = 8'hC0;
    localparam logic [1:0] SEL_NONE  = 2'b11;
    localparam logic [1:0] SEL_TEN   = 2'b01;
    localparam logic [1:0] SEL_ONE   = 2'b10;

    function automatic logic is_lead_zero(input logic [7:0] pat);
        return (pat == GLYPH_0);
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       ten_q, ten_d;
    logic [7:0]       one_q, one_d;
    logic [7:0]       smg_q, smg_d;
    logic [1:0]       scan_q, scan_d;
    logic             done_q, done_d;
    logic             frame_end_s;

    // Next state, dwell counter and shadow loads
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_ONE;
        ten_d       = ten_q;
        one_d       = one_q;
        frame_end_s = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (Scan_En) begin
                    state_d = TEN_ON;
                    ten_d   = Ten_SMG_Data;
                    one_d   = One_SMG_Data;
                end else begin
                    state_d = IDLE;
                end
            end
            TEN_ON: begin
                if (cnt_q == DIG_LAST) begin
                    cnt_d   = '0;
                    state_d = HAS_BLANK ? TEN_BLANK : ONE_ON;
                end else begin
                    state_d = TEN_ON;
                end
            end
            TEN_BLANK: begin
                if (cnt_q == BLK_LAST) begin
                    cnt_d   = '0;
                    state_d = ONE_ON;
                end else begin
                    state_d = TEN_BLANK;
                end
            end
            ONE_ON: begin
                if (cnt_q == DIG_LAST) begin
                    cnt_d = '0;
                    if (HAS_BLANK) begin
                        state_d = ONE_BLANK;
                    end else begin
                        frame_end_s = 1'b1;
                    end
                end else begin
                    state_d = ONE_ON;
                end
            end
            ONE_BLANK: begin
                if (cnt_q == BLK_LAST) begin
                    cnt_d       = '0;
                    frame_end_s = 1'b1;
                end else begin
                    state_d = ONE_BLANK;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Scan_En is only honoured here and in IDLE, so a frame always completes
        if (frame_end_s) begin
            if (Scan_En) begin
                state_d = TEN_ON;
                ten_d   = Ten_SMG_Data;
                one_d   = One_SMG_Data;
            end else begin
                state_d = IDLE;
            end
        end else begin
            state_d = state_d;
        end
    end

    // Output values for the state being entered, so registered outputs track the state
    always_comb begin
        smg_d  = SEG_DARK;
        scan_d = SEL_NONE;
        done_d = 1'b0;
        case (state_d)
            TEN_ON: begin
                if (LZ_En && is_lead_zero(ten_d)) begin
                    smg_d  = SEG_DARK;
                    scan_d = SEL_NONE;
                end else begin
                    smg_d  = ten_d;
                    scan_d = SEL_TEN;
                end
            end
            ONE_ON: begin
                smg_d  = one_d;
                scan_d = SEL_ONE;
                if (!HAS_BLANK && (cnt_d == DIG_LAST)) begin
                    done_d = 1'b1;
                end else begin
                    done_d = 1'b0;
                end
            end
            ONE_BLANK: begin
                if (cnt_d == BLK_LAST) begin
                    done_d = 1'b1;
                end else begin
                    done_d = 1'b0;
                end
            end
            default: begin
                smg_d  = SEG_DARK;
                scan_d = SEL_NONE;
                done_d = 1'b0;
            end
        endcase
    end

    // State, counter, shadows and outputs with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ten_q   <= SEG_DARK;
            one_q   <= SEG_DARK;
            smg_q   <= SEG_DARK;
            scan_q  <= SEL_NONE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ten_q   <= ten_d;
            one_q   <= one_d;
            smg_q   <= smg_d;
            scan_q  <= scan_d;
            done_q  <= done_d;
        end
    end

    assign SMG_Data   = smg_q;
    assign Scan_Sig   = scan_q;
    assign Frame_Done = done_q;

endmodule

// File: tb/tb_smg_scan_module.sv
// Self-checking bench for smg_scan_module: frame table plus hand-written corner sequences,
// with expected outputs queued per cycle and compared as the DUT produces them.
module tb_smg_scan_module;

    localparam int TD = 4;
    localparam int TB = 2;

    logic       clk;
    logic       rst_n, rst0_n;
    logic [7:0] ten, one;
    logic       scan_en, lz_en;
    logic [7:0] smg, smg0;
    logic [1:0] sel, sel0;
    logic       done, done0;

    smg_scan_module #(.T_DIGIT(TD), .T_BLANK(TB), .CNT_W(4)) dut (
        .CLK(clk), .RSTn(rst_n), .Ten_SMG_Data(ten), .One_SMG_Data(one),
        .Scan_En(scan_en), .LZ_En(lz_en),
        .SMG_Data(smg), .Scan_Sig(sel), .Frame_Done(done)
    );

    smg_scan_module #(.T_DIGIT(TD), .T_BLANK(0), .CNT_W(4)) dut0 (
        .CLK(clk), .RSTn(rst0_n), .Ten_SMG_Data(ten), .One_SMG_Data(one),
        .Scan_En(scan_en), .LZ_En(lz_en),
        .SMG_Data(smg0), .Scan_Sig(sel0), .Frame_Done(done0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] smg;
        logic [1:0] scan;
        logic       done;
    } exp_t;

    typedef struct {
        logic [7:0] ten;
        logic [7:0] one;
        logic       lz;
        logic [1:0] t_scan;
        logic [7:0] t_smg;
        logic [7:0] o_smg;
    } vec_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic push(input logic [7:0] s, input logic [1:0] sc, input logic d, input int n);
        exp_t e;
        e.smg  = s;
        e.scan = sc;
        e.done = d;
        for (int i = 0; i < n; i++) sb_q.push_back(e);
    endtask

    task automatic push_frame(input logic [1:0] t_scan, input logic [7:0] t_smg,
                              input logic [7:0] o_smg, input int tb);
        push(t_smg, t_scan, 1'b0, TD);
        if (tb > 0) begin
            push(8'hFF, 2'b11, 1'b0, tb);
            push(o_smg, 2'b10, 1'b0, TD);
            push(8'hFF, 2'b11, 1'b0, tb - 1);
            push(8'hFF, 2'b11, 1'b1, 1);
        end else begin
            push(o_smg, 2'b10, 1'b0, TD - 1);
            push(o_smg, 2'b10, 1'b1, 1);
        end
    endtask

    task automatic run(input string tag, input int n, input int which);
        exp_t e, a;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            a = (which == 0) ? {smg, sel, done} : {smg0, sel0, done0};
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL %s[%0d] scoreboard empty, actual %h/%b/%b", tag, i, a.smg, a.scan, a.done);
            end else begin
                e = sb_q.pop_front();
                if (a !== e) begin
                    fails++;
                    $display("FAIL %s[%0d] actual smg=%h scan=%b done=%b, required smg=%h scan=%b done=%b",
                             tag, i, a.smg, a.scan, a.done, e.smg, e.scan, e.done);
                end
            end
            tests++;
            if (a.scan == 2'b00) begin
                fails++;
                $display("FAIL %s[%0d]_sel actual scan=00, required not 00", tag, i);
            end
        end
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'hA4, 8'hB0, 1'b0, 2'b01, 8'hA4, 8'hB0};
        vecs[1] = '{8'hA4, 8'hB0, 1'b0, 2'b01, 8'hA4, 8'hB0};
        vecs[2] = '{8'hC0, 8'h92, 1'b1, 2'b11, 8'hFF, 8'h92};
        vecs[3] = '{8'hC0, 8'h92, 1'b0, 2'b01, 8'hC0, 8'h92};
        vecs[4] = '{8'hA4, 8'h92, 1'b1, 2'b01, 8'hA4, 8'h92};
        vecs[5] = '{8'hC0, 8'hB0, 1'b1, 2'b11, 8'hFF, 8'hB0};

        rst_n   = 1'b0;
        rst0_n  = 1'b0;
        ten     = 8'hA4;
        one     = 8'hB0;
        scan_en = 1'b1;
        lz_en   = 1'b0;

        // Reset held with scanning requested: dark throughout
        push(8'hFF, 2'b11, 1'b0, 3);
        run("reset", 3, 0);

        // Table of back-to-back frames; inputs change just before each loading edge
        rst_n = 1'b1;
        for (int v = 0; v < 6; v++) begin
            ten   = vecs[v].ten;
            one   = vecs[v].one;
            lz_en = vecs[v].lz;
            push_frame(vecs[v].t_scan, vecs[v].t_smg, vecs[v].o_smg, TB);
            run($sformatf("vec%0d", v), 2 * (TD + TB), 0);
        end

        // Mid-frame pattern change must not tear the current frame
        ten   = 8'hA4;
        one   = 8'hB0;
        lz_en = 1'b0;
        push_frame(2'b01, 8'hA4, 8'hB0, TB);
        run("tear_a", 2, 0);
        one = 8'hF9;
        run("tear_b", 2 * (TD + TB) - 2, 0);
        push_frame(2'b01, 8'hA4, 8'hF9, TB);
        run("tear_next", 2 * (TD + TB), 0);

        // Scan_En dropped during ONE_ON: frame completes, then IDLE
        push_frame(2'b01, 8'hA4, 8'hF9, TB);
        run("stop_a", TD + TB + 1, 0);
        scan_en = 1'b0;
        run("stop_b", TD + TB - 1, 0);
        push(8'hFF, 2'b11, 1'b0, 3);
        run("idle", 3, 0);
        scan_en = 1'b1;
        push_frame(2'b01, 8'hA4, 8'hF9, TB);
        run("restart", 2 * (TD + TB), 0);

        // Reset pulse mid ONE_ON
        push_frame(2'b01, 8'hA4, 8'hF9, TB);
        run("rst_mid", TD + TB + 1, 0);
        sb_q.delete();
        rst_n   = 1'b0;
        scan_en = 1'b0;
        push(8'hFF, 2'b11, 1'b0, 1);
        run("rst_pulse", 1, 0);
        tests++;
        if (dut.ten_q !== 8'hFF || dut.one_q !== 8'hFF) begin
            fails++;
            $display("FAIL rst_shadow actual ten=%h one=%h, required FF/FF", dut.ten_q, dut.one_q);
        end
        rst_n = 1'b1;
        push(8'hFF, 2'b11, 1'b0, 1);
        run("rst_idle", 1, 0);
        scan_en = 1'b1;
        ten     = 8'h99;
        one     = 8'h82;
        push_frame(2'b01, 8'h99, 8'h82, TB);
        run("rst_frame", 2 * (TD + TB), 0);

        // T_BLANK = 0 instance: 8-cycle frames, done on last ONE_ON cycle
        sb_q.delete();
        push(8'hFF, 2'b11, 1'b0, 1);
        run("nb_reset", 1, 1);
        rst0_n = 1'b1;
        push_frame(2'b01, 8'h99, 8'h82, 0);
        push_frame(2'b01, 8'h99, 8'h82, 0);
        run("noblank", 4 * TD, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
